// File: rtl/port_uart_tx_if.sv
// Output-port side of the serial transmitter: write strobe and byte in, serial line and status out.
// The master side is the datapath (or bench); the transmitter is the slave.
interface port_uart_tx_if;
    logic       wr;
    logic [7:0] din;
    logic       clr_ovr;
    logic       tx;
    logic [7:0] status;

    modport master (
        output wr,
        output din,
        output clr_ovr,
        input  tx,
        input  status
    );

    modport slave (
        input  wr,
        input  din,
        input  clr_ovr,
        output tx,
        output status
    );
endinterface

// File: rtl/port_uart_tx.sv
// 8N1 serial transmitter fed from a datapath output port through a one-entry holding register.
// Status {5'b0, ovr, hold_full, busy} is taken straight from flops for polling via an input port.
module port_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic           clk,
    input  logic           reset,
    port_uart_tx_if.slave  bus
);

    localparam int unsigned CntW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CntW-1:0] CntReload = CntW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e          state_q;
    logic [CntW-1:0] cnt_q;
    logic [2:0]      idx_q;
    logic [7:0]      shift_q;
    logic [7:0]      hold_q;
    logic            hold_full_q;
    logic            ovr_q;
    logic            tx_q;

    logic bit_end;
    logic load;
    logic overrun;

    always_comb begin
        bit_end = (cnt_q == '0);
        // Hold drains on entry from IDLE or straight out of the stop bit for back-to-back frames.
        load    = hold_full_q &&
                  ((state_q == StIdle) || ((state_q == StStop) && bit_end));
        overrun = bus.wr && hold_full_q && !load;
    end

    // Holding register and sticky overrun flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            ovr_q       <= 1'b0;
        end else begin
            if (load) begin
                hold_full_q <= bus.wr;
            end else if (bus.wr) begin
                hold_full_q <= 1'b1;
            end
            if (bus.wr && (load || !hold_full_q)) begin
                hold_q <= bus.din;
            end
            if (overrun) begin
                ovr_q <= 1'b1;
            end else if (bus.clr_ovr) begin
                ovr_q <= 1'b0;
            end
        end
    end

    // Frame sequencer; tx is registered with the value for the state being entered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else if (load) begin
            state_q <= StStart;
            shift_q <= hold_q;
            cnt_q   <= CntReload;
            idx_q   <= '0;
            tx_q    <= 1'b0;
        end else if (state_q == StIdle) begin
            tx_q <= 1'b1;
        end else if (!bit_end) begin
            cnt_q <= cnt_q - CntW'(1);
        end else begin
            cnt_q <= CntReload;
            case (state_q)
                StStart: begin
                    state_q <= StData;
                    idx_q   <= '0;
                    tx_q    <= shift_q[0];
                end
                StData: begin
                    if (idx_q == 3'd7) begin
                        state_q <= StStop;
                        tx_q    <= 1'b1;
                    end else begin
                        shift_q <= {1'b0, shift_q[7:1]};
                        idx_q   <= idx_q + 3'd1;
                        tx_q    <= shift_q[1];
                    end
                end
                StStop: begin
                    state_q <= StIdle;
                    tx_q    <= 1'b1;
                end
                default: begin
                    state_q <= StIdle;
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end

    assign bus.tx     = tx_q;
    assign bus.status = {5'b0, ovr_q, hold_full_q, (state_q != StIdle)};

endmodule

// File: tb/tb_port_uart_tx.sv
// Randomised and directed bench for port_uart_tx against a frame-timeline model of the line.
module tb_port_uart_tx;

    localparam int CPB       = 4;
    localparam int FRAME_LEN = 10 * CPB;

    logic clk;
    logic reset;

    port_uart_tx_if bus_if ();

    port_uart_tx #(
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp;
    int n_err;

    // Model: the line is a 10-bit frame replayed over FRAME_LEN cycles, plus a one-byte hold.
    logic       m_active;
    int         m_pos;
    logic [9:0] m_frame;
    logic       m_hold_valid;
    logic [7:0] m_hold;
    logic       m_ovr;

    task automatic model_reset();
        m_active     = 1'b0;
        m_pos        = 0;
        m_frame      = '1;
        m_hold_valid = 1'b0;
        m_hold       = '0;
        m_ovr        = 1'b0;
    endtask

    task automatic model_step(input logic w, input logic [7:0] d, input logic c);
        logic ending;
        logic ld;
        logic over;
        if (reset) begin
            model_reset();
            return;
        end
        ending = m_active && (m_pos == FRAME_LEN - 1);
        ld     = m_hold_valid && (!m_active || ending);
        over   = w && m_hold_valid && !ld;
        if (ld) begin
            m_active     = 1'b1;
            m_pos        = 0;
            m_frame      = {1'b1, m_hold, 1'b0};
            m_hold_valid = w;
            if (w) m_hold = d;
        end else begin
            if (ending) m_active = 1'b0;
            else if (m_active) m_pos = m_pos + 1;
            if (w && !m_hold_valid) begin
                m_hold_valid = 1'b1;
                m_hold       = d;
            end
        end
        if (over) m_ovr = 1'b1;
        else if (c) m_ovr = 1'b0;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic compare_model();
        logic       exp_tx;
        logic [7:0] exp_st;
        exp_tx = m_active ? m_frame[m_pos / CPB] : 1'b1;
        exp_st = {5'b0, m_ovr, m_hold_valid, m_active};
        check("model_tx", 32'(bus_if.tx), 32'(exp_tx));
        check("model_status", 32'(bus_if.status), 32'(exp_st));
    endtask

    // One clock: drive inputs, advance model at the edge, compare at the falling edge.
    task automatic cycle(input logic w, input logic [7:0] d, input logic c);
        bus_if.wr      = w;
        bus_if.din     = d;
        bus_if.clr_ovr = c;
        @(posedge clk);
        model_step(w, d, c);
        @(negedge clk);
        compare_model();
    endtask

    task automatic drain();
        int i;
        i = 0;
        while ((m_active || m_hold_valid) && i < 400) begin
            cycle(1'b0, 8'h00, 1'b0);
            i++;
        end
        check("drain_timeout", 32'(m_active || m_hold_valid), 32'd0);
        cycle(1'b0, 8'h00, 1'b0);
    endtask

    logic [39:0] samp;
    logic [9:0]  exp_bits;
    int          busy_cnt;

    initial begin
        n_cmp          = 0;
        n_err          = 0;
        bus_if.wr      = 1'b0;
        bus_if.din     = '0;
        bus_if.clr_ovr = 1'b0;
        reset          = 1'b1;
        model_reset();
        cycle(1'b0, 8'h00, 1'b0);
        cycle(1'b0, 8'h00, 1'b0);
        reset = 1'b0;
        cycle(1'b0, 8'h00, 1'b0);
        check("reset_status", 32'(bus_if.status), 32'h00);
        check("reset_tx", 32'(bus_if.tx), 32'd1);

        // Single frame of A5 sampled once per bit.
        cycle(1'b1, 8'hA5, 1'b0);
        check("a5_hold_status", 32'(bus_if.status), 32'h02);
        check("a5_tx_before_start", 32'(bus_if.tx), 32'd1);
        busy_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            cycle(1'b0, 8'h00, 1'b0);
            samp[i] = bus_if.tx;
            if (bus_if.status[0]) busy_cnt++;
        end
        exp_bits = 10'b1101001010;
        for (int k = 0; k < 10; k++) begin
            check($sformatf("a5_bit%0d", k), 32'(samp[4*k]), 32'(exp_bits[k]));
        end
        check("a5_busy_cycles", 32'(busy_cnt), 32'd40);
        cycle(1'b0, 8'h00, 1'b0);
        check("a5_done_status", 32'(bus_if.status), 32'h00);

        // Back-to-back frames, then overrun and clr/overrun collision during frame 2.
        cycle(1'b1, 8'h01, 1'b0);
        cycle(1'b0, 8'h00, 1'b0);
        cycle(1'b1, 8'h80, 1'b0);
        for (int i = 0; i < 38; i++) cycle(1'b0, 8'h00, 1'b0);
        check("b2b_stop_tx", 32'(bus_if.tx), 32'd1);
        check("b2b_stop_status", 32'(bus_if.status), 32'h03);
        cycle(1'b0, 8'h00, 1'b0);
        check("b2b_start_tx", 32'(bus_if.tx), 32'd0);
        check("b2b_start_status", 32'(bus_if.status), 32'h01);
        cycle(1'b1, 8'h5A, 1'b0);
        cycle(1'b1, 8'h3C, 1'b0);
        check("ovr_status", 32'(bus_if.status), 32'h07);
        cycle(1'b1, 8'hFF, 1'b1);
        check("ovr_set_wins", 32'(bus_if.status), 32'h07);
        cycle(1'b0, 8'h00, 1'b1);
        check("ovr_cleared", 32'(bus_if.status), 32'h03);
        drain();

        // Write landing exactly on the IDLE->START load edge.
        cycle(1'b1, 8'hB1, 1'b0);
        check("load_wr_pre", 32'(bus_if.status), 32'h02);
        cycle(1'b1, 8'h4E, 1'b0);
        check("load_wr_status", 32'(bus_if.status), 32'h03);
        drain();

        // Asynchronous reset in the middle of a zero data bit.
        cycle(1'b1, 8'h00, 1'b0);
        for (int i = 0; i < 10; i++) cycle(1'b0, 8'h00, 1'b0);
        check("pre_reset_tx", 32'(bus_if.tx), 32'd0);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_tx", 32'(bus_if.tx), 32'd1);
        check("async_reset_status", 32'(bus_if.status), 32'h00);
        model_reset();
        cycle(1'b0, 8'h00, 1'b0);
        reset = 1'b0;
        cycle(1'b1, 8'hC3, 1'b0);
        drain();

        // Random traffic, including bursts that overrun and clears at random times.
        for (int i = 0; i < 4000; i++) begin
            logic       w;
            logic       c;
            logic [7:0] d;
            w = ($urandom_range(0, 24) == 0) || ((i % 500) < 6 && $urandom_range(0, 1) == 0);
            c = ($urandom_range(0, 19) == 0);
            d = 8'($urandom);
            cycle(w, d, c);
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/port_uart_tx.md
Name: port_uart_tx

Overview:
- Serial transmitter that consumes the datapath's output-port traffic.
- CPU writes a byte to an output port; this block buffers it in a one-entry holding register and shifts it out as an 8N1 frame on a single line.
- A status byte feeds back into a datapath input port, so software can poll busy/full/overrun.
- One instance per output port that needs serial output; wr connects to that port's owe strobe, din to the register-file read data rd1.

Parameters:
CLKS_PER_BIT, 16, clock cycles per serial bit (>=2)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
wr  input  1  write strobe (port owe); sampled on rising clk
din  input  8  byte to transmit, valid when wr=1
clr_ovr  input  1  synchronous clear of sticky overrun flag
tx  output  1  serial line, idle high
status  output  8  {5'b0, ovr, hold_full, busy}, registered-state derived, feeds an input port

Behaviour:
- Reset (async, immediate): tx=1, FSM=IDLE, hold_full=0, ovr=0, baud counter=0, bit index=0, status=8'h00. Reset mid-frame aborts the frame; tx goes high without waiting for clk.
- Holding register:
  - wr=1 with hold_full=0: capture din; hold_full=1 after the edge.
  - wr=1 with hold_full=1 and no load this cycle: din discarded, hold unchanged, ovr=1 (sticky).
  - wr=1 in the same cycle the shifter loads from hold: new din is captured, hold_full stays 1, no overrun.
- Sticky overrun: clr_ovr=1 clears ovr at the edge. If clr_ovr and a new overrun occur in the same cycle, set wins (ovr=1).
- FSM states:
  - IDLE: tx=1. If hold_full=1, move hold into the shift register, clear hold_full (unless the simultaneous write rule applies), go to START, load baud counter with CLKS_PER_BIT-1.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx=shift[0], LSB first. Each bit lasts CLKS_PER_BIT cycles. The shift register shifts right at the end of each bit. After bit 7 go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. Then, if hold_full=1, load directly into START on the next edge, giving back-to-back frames with exactly one stop bit and no idle gap. Otherwise go to IDLE.
- Baud counter counts down. A bit ends when the counter is 0 at a rising edge, then the counter reloads CLKS_PER_BIT-1.
- tx is driven from a register, so it is glitch-free.
- Latency: with wr at edge N into an idle, empty block, hold_full=1 after N, tx falls after edge N+1. A frame occupies exactly 10*CLKS_PER_BIT cycles.
- busy=1 whenever FSM != IDLE. hold_full and ovr are reflected in status directly from their flops, so there are no combinational paths from inputs to outputs.
- din is don't-care when wr=0.

Test Plan:
- CLKS_PER_BIT=4: reset, then wr with din=8'hA5. Required: tx falls one cycle after hold_full=1, then holds 0,1,0,1,0,0,1,0,1,1, each bit for 4 cycles. busy=1 for 40 cycles, then status=8'h00.
- Write 8'h01 then, two cycles later, 8'h80. Required: both frames sent back-to-back. Stop bit of frame 1 is exactly 4 cycles, then tx=0 start with no idle. hold_full drops when frame 2 loads.
- While frame 1 is shifting and hold is full, write 8'h3C. Required: status=8'h07 (busy, hold_full, ovr). The 3C byte never appears on tx. Pulse clr_ovr: status bit2 returns to 0.
- Assert wr in the exact IDLE->START load cycle (hold_full=1). Required: new byte captured, hold_full stays 1, ovr stays 0, both bytes transmitted in order.
- Assert reset asynchronously mid-DATA of 8'h00 (tx=0). Required: tx=1 and status=8'h00 before the next clk edge. After release, a new write transmits normally.
- Assert clr_ovr and trigger an overrun in the same cycle. Required: ovr=1 afterward.
